// File: rtl/rx_controller_pkg.sv
// rtl/rx_controller_pkg.sv - shared UART receive definitions
package rx_controller_pkg;

  // Width of one serial data character.
  localparam int DATA_WIDTH = 8;

  // State encodings shared with the transmit side, plus WAIT_IDLE.
  localparam logic [2:0] ST_IDLE      = 3'b000;
  localparam logic [2:0] ST_START_BIT = 3'b001;
  localparam logic [2:0] ST_DATA_BITS = 3'b010;
  localparam logic [2:0] ST_STOP_BIT  = 3'b011;
  localparam logic [2:0] ST_WAIT_IDLE = 3'b100;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START_BIT = ST_START_BIT,
    DATA_BITS = ST_DATA_BITS,
    STOP_BIT  = ST_STOP_BIT,
    WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_e;

  // Timer value at which the start bit is re-checked (its centre).
  function automatic logic [15:0] mid_count(input int clks_per_bit);
    return 16'((clks_per_bit - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchronizer for the serial input, presets to idle-high
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw line one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Stages come out of reset high so an idle line never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_controller.sv
// rtl/rx_controller.sv - UART receiver: start/data/stop framing into a one-entry holding register
module rx_controller
  import rx_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       system_clk,
  input  logic       system_reset_n,
  input  logic       rx_serial_data,
  input  logic       rx_read_ack,
  output logic [7:0] rx_data_byte,
  output logic       rx_valid_flag,
  output logic       rx_busy_flag,
  output logic       rx_frame_error_flag,
  output logic       rx_overrun_flag
);

  localparam logic [15:0] TIMER_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TIMER_MID  = mid_count(CLKS_PER_BIT);

  logic s;

  rx_state_e             state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  frame_good;
  logic                  frame_bad;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (system_clk),
    .rst_n(system_reset_n),
    .din  (rx_serial_data),
    .dout (s)
  );

  // Frame sequencing: start detect, bit timing, data shift and stop check.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d   = 16'd0;
        bit_cnt_d = 3'd0;
        if (!s) begin
          // At one clock per bit this sample already is the whole start bit.
          if (CLKS_PER_BIT == 1) begin
            state_d = DATA_BITS;
          end else begin
            state_d = START_BIT;
          end
        end
      end
      START_BIT: begin
        if (timer_q == TIMER_MID) begin
          timer_d = 16'd0;
          // A line that is high again at mid-bit was only a glitch.
          state_d = s ? IDLE : DATA_BITS;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA_BITS: begin
        if (timer_q == TIMER_LAST) begin
          timer_d           = 16'd0;
          shift_d[bit_cnt_q] = s;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP_BIT: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = 16'd0;
          if (s) begin
            frame_good = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) is absorbed here until it returns high.
        timer_d = 16'd0;
        if (s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = 16'd0;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Holding register handshake plus registered status outputs.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    ferr_d  = frame_bad;
    busy_d  = (state_d != IDLE);
    if (frame_good) begin
      // An ack in the completion cycle frees the slot for the new byte.
      if (!valid_q || rx_read_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_read_ack) begin
      valid_d = 1'b0;
    end
  end

  // All receiver state returns to idle values on reset.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q   <= IDLE;
      timer_q   <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data_byte        = data_q;
  assign rx_valid_flag       = valid_q;
  assign rx_busy_flag        = busy_q;
  assign rx_frame_error_flag = ferr_q;
  assign rx_overrun_flag     = ovr_q;

endmodule

// File: tb/tb_rx_controller.sv
// tb/tb_rx_controller.sv - randomized bench for rx_controller against a frame-level reference model
module tb_rx_controller;

  localparam int S1    = 2;
  localparam int S16   = 3;
  localparam int CPB16 = 16;
  localparam int NPIN  = 2400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pin1  = 1'b1;
  logic ack1  = 1'b0;
  logic pin16 = 1'b1;
  logic ack16 = 1'b0;
  logic [7:0] byte1, byte16;
  logic valid1, busy1, ferr1, ovr1;
  logic valid16, busy16, ferr16, ovr16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rx_controller #(.CLKS_PER_BIT(1), .SYNC_STAGES(S1)) u_dut1 (
    .system_clk         (clk),
    .system_reset_n     (rst_n),
    .rx_serial_data     (pin1),
    .rx_read_ack        (ack1),
    .rx_data_byte       (byte1),
    .rx_valid_flag      (valid1),
    .rx_busy_flag       (busy1),
    .rx_frame_error_flag(ferr1),
    .rx_overrun_flag    (ovr1)
  );

  rx_controller #(.CLKS_PER_BIT(CPB16), .SYNC_STAGES(S16)) u_dut16 (
    .system_clk         (clk),
    .system_reset_n     (rst_n),
    .rx_serial_data     (pin16),
    .rx_read_ack        (ack16),
    .rx_data_byte       (byte16),
    .rx_valid_flag      (valid16),
    .rx_busy_flag       (busy16),
    .rx_frame_error_flag(ferr16),
    .rx_overrun_flag    (ovr16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Activity monitor for the CLKS_PER_BIT=16 receiver.
  logic mon_clr = 1'b0;
  int   busy16_cnt = 0, ferr16_cnt = 0, ovr16_cnt = 0, rise16_cyc = -1;
  logic valid16_prev = 1'b0;
  always @(negedge clk) begin
    valid16_prev <= valid16;
    if (mon_clr) begin
      busy16_cnt <= 0;
      ferr16_cnt <= 0;
      ovr16_cnt  <= 0;
      rise16_cyc <= -1;
    end else begin
      if (busy16) busy16_cnt <= busy16_cnt + 1;
      if (ferr16) ferr16_cnt <= ferr16_cnt + 1;
      if (ovr16)  ovr16_cnt  <= ovr16_cnt + 1;
      if (valid16 && !valid16_prev) rise16_cyc <= cyc;
    end
  end

  // Pin schedule and per-cycle expectations for the one-clock-per-bit receiver.
  bit         pin_arr  [NPIN];
  bit         busy_exp [NPIN+32];
  bit         ev_at    [NPIN+32];
  bit         ev_good  [NPIN+32];
  logic [7:0] ev_byte  [NPIN+32];
  int         idx = 0;

  task automatic push(input bit b);
    pin_arr[idx] = b;
    idx++;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic send16(input logic [7:0] b, output int k);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    k  = cyc;
    for (int i = 0; i < 10; i++) begin
      repeat (CPB16) begin
        pin16 = fr[i];
        @(negedge clk);
      end
    end
  endtask

  task automatic send1(input logic [7:0] b, output int k);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    k  = cyc;
    for (int i = 0; i < 10; i++) begin
      pin1 = fr[i];
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] fixed [4];
    logic [7:0] b;
    logic [7:0] m_byte;
    logic       m_valid, m_ferr, m_ovr, good;
    int         k, h, last, nfr, gap, lat;

    fixed[0] = 8'hA5; fixed[1] = 8'h00; fixed[2] = 8'hFF; fixed[3] = 8'h5A;

    // Build a random frame stream: good frames, back-to-back runs and breaks.
    repeat (4) push(1'b1);
    nfr = 0;
    while (idx < NPIN - 50) begin
      gap = (nfr < 4) ? 0 : $urandom_range(0, 3);
      repeat (gap) push(1'b1);
      b    = (nfr < 4) ? fixed[nfr] : 8'($urandom);
      good = (nfr < 4) || ($urandom_range(0, 5) != 0);
      k    = idx;
      push(1'b0);
      for (int i = 0; i < 8; i++) push(b[i]);
      if (good) begin
        push(1'b1);
        last = k + S1 + 9;
      end else begin
        push(1'b0);
        repeat ($urandom_range(0, 20)) push(1'b0);
        h = idx;
        push(1'b1);
        last = h + S1;
      end
      for (int c = k + S1 + 1; c <= last; c++) busy_exp[c] = 1'b1;
      ev_at[k + S1 + 9]   = 1'b1;
      ev_good[k + S1 + 9] = good;
      ev_byte[k + S1 + 9] = b;
      nfr++;
    end
    while (idx < NPIN) push(1'b1);

    // Reset values on both receivers.
    repeat (3) @(negedge clk);
    check("rst_byte1", byte1, 8'h00);
    check("rst_valid1", valid1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_ferr1", ferr1, 1'b0);
    check("rst_ovr1", ovr1, 1'b0);
    check("rst_byte16", byte16, 8'h00);
    check("rst_valid16", valid16, 1'b0);
    check("rst_busy16", busy16, 1'b0);
    rst_n = 1'b1;

    // Random stream against the frame-level holding-register model.
    m_valid = 1'b0; m_byte = 8'h00;
    for (int c = 0; c < NPIN; c++) begin
      pin1   = pin_arr[c];
      ack1   = ($urandom_range(0, 3) == 0);
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (ev_at[c] && ev_good[c]) begin
        if (!m_valid || ack1) begin
          m_byte  = ev_byte[c];
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        if (ev_at[c]) m_ferr = 1'b1;
        if (ack1) m_valid = 1'b0;
      end
      @(negedge clk);
      check("valid1", valid1, m_valid);
      check("byte1", byte1, m_byte);
      check("busy1", busy1, busy_exp[c+1]);
      check("ferr1", ferr1, m_ferr);
      check("ovr1", ovr1, m_ovr);
    end
    ack1 = 1'b0;
    pin1 = 1'b1;

    // Slow receiver: a short low glitch must be rejected at mid start bit.
    mon_clear();
    repeat (3) begin pin16 = 1'b0; @(negedge clk); end
    pin16 = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("glitch_busy_seen", busy16_cnt > 0, 1'b1);
    check("glitch_busy_len", busy16_cnt <= (CPB16 - 1) / 2 + 2, 1'b1);
    check("glitch_valid", rise16_cyc, -1);
    check("glitch_ferr", ferr16_cnt, 0);
    check("glitch_ovr", ovr16_cnt, 0);
    check("glitch_idle", busy16, 1'b0);

    // Slow receiver: full frames land one clock after the stop mid-sample (+/-1).
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'hC3 : 8'($urandom);
      mon_clear();
      send16(b, k);
      repeat (4) @(negedge clk);
      #1;
      lat = rise16_cyc - k;
      check("cpb16_latency", (lat >= 9 * CPB16 + CPB16 / 2 + S16) &&
                             (lat <= 9 * CPB16 + CPB16 / 2 + S16 + 2), 1'b1);
      check("cpb16_byte", byte16, b);
      check("cpb16_valid", valid16, 1'b1);
      check("cpb16_ferr", ferr16_cnt, 0);
      check("cpb16_ovr", ovr16_cnt, 0);
      ack16 = 1'b1;
      @(negedge clk);
      ack16 = 1'b0;
      check("cpb16_ack_clear", valid16, 1'b0);
    end

    // Reset during bit 4 of 8'hF0, then a clean 8'h81.
    repeat (5) @(negedge clk);
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 10; i++) begin
        pin1 = fr[i];
        if (i == S1 + 5) begin
          rst_n = 1'b0;
          #1;
          check("midrst_busy", busy1, 1'b0);
          check("midrst_valid", valid1, 1'b0);
          check("midrst_byte", byte1, 8'h00);
          check("midrst_ferr", ferr1, 1'b0);
          check("midrst_ovr", ovr1, 1'b0);
        end
        if (i == S1 + 6) rst_n = 1'b1;
        @(negedge clk);
      end
    end
    pin1 = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_busy", busy1, 1'b0);
    check("postrst_valid", valid1, 1'b0);
    send1(8'h81, k);
    repeat (S1 - 1) @(negedge clk);
    check("post_81_early", valid1, 1'b0);
    @(negedge clk);
    check("post_81_valid", valid1, 1'b1);
    check("post_81_byte", byte1, 8'h81);
    check("post_81_ferr", ferr1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_controller.md
# rx_controller

UART receive controller: the far end of the serial link driven by the transmit controller. Synchronizes the incoming serial line, detects and validates the start bit, shifts in 8 data bits LSB-first, and checks the stop bit. Accepted bytes are held in a one-entry holding register with valid/acknowledge handshake, framing-error and overrun reporting. Sits between the serial pin and the byte-level consumer logic.

## Interface
- CLKS_PER_BIT, default 1: system clocks per serial bit. Value 1 matches the transmit controller, which sends one bit per clock. Legal range 1..65535.
- SYNC_STAGES, default 2: flops in the input synchronizer. Legal range 2..4.
- system_clk  in  1  sole clock; all logic on rising edge.
- system_reset_n  in  1  asynchronous, active-low reset.
- rx_serial_data  in  1  serial line; idles high, asynchronous to system_clk.
- rx_read_ack  in  1  consumer pulse; clears rx_valid_flag.
- rx_data_byte  out  8  holding register; reset 8'h00.
- rx_valid_flag  out  1  level; holding register contains an unread byte; reset 0.
- rx_busy_flag  out  1  high whenever FSM is not IDLE; reset 0.
- rx_frame_error_flag  out  1  one-cycle pulse on bad stop bit; reset 0.
- rx_overrun_flag  out  1  one-cycle pulse when a good frame is dropped; reset 0.

## Operation
- Synchronizer flops reset to 1 (idle line). FSM samples only the synchronized line `s`.
- Bit timer counts 0..CLKS_PER_BIT-1. Bit counter runs 0..7.
- **IDLE:** bit counter = 0, timer = 0. On `s`==0:
  - If CLKS_PER_BIT==1, go to DATA_BITS; this sample is the start bit.
  - Otherwise, go to START_BIT.
- **START_BIT:** count to mid-bit, (CLKS_PER_BIT-1)/2 (integer division).
  - At mid-bit, if `s`==0, go to DATA_BITS and restart the timer.
  - At mid-bit, if `s`==1, treat it as a glitch: return to IDLE with no flags.
- **DATA_BITS:** every CLKS_PER_BIT clocks, sample `s` into shift register bit [bit counter].
  - After bit 7, go to STOP_BIT.
- **STOP_BIT:** after CLKS_PER_BIT clocks, sample `s`.
  - If `s`==1, the frame is good. Load or drop the byte per the holding rules, then go to IDLE.
  - If `s`==0, pulse rx_frame_error_flag, discard the byte, and go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `s`==1, then go to IDLE. A held-low line (break) therefore never produces repeated frames.
- Holding-register rules on a good frame:
  - rx_valid_flag==0: load rx_data_byte, set rx_valid_flag.
  - rx_valid_flag==1 with rx_read_ack==0: keep the old byte, pulse rx_overrun_flag.
  - rx_valid_flag==1 with rx_read_ack==1 in the same cycle: load the new byte, rx_valid_flag stays 1, no overrun.
- rx_read_ack while rx_valid_flag==0 is ignored.
- Undefined state encoding: go to IDLE next cycle.
- Reset mid-frame: all state and outputs return to reset values immediately. Any partial byte is lost.

## Timing
- Synchronizer latency: `s`(t) = rx_serial_data(t − SYNC_STAGES).
- CLKS_PER_BIT=1, start bit on the pin in cycle k:
  - data bit i sampled from `s` in cycle k+SYNC_STAGES+1+i;
  - stop bit sampled in cycle k+SYNC_STAGES+9;
  - rx_valid_flag high from cycle k+SYNC_STAGES+10.
- The same timing applies to frame-error and overrun pulses.
- Minimum inter-frame idle is zero bit times after the stop sample. IDLE re-arms the cycle after STOP_BIT, so it accepts the transmit controller's back-to-back frames (stop bit plus one idle cycle).
- General CLKS_PER_BIT: each bit is sampled at its mid-point ±1 clock. rx_valid_flag rises one clock after the stop-bit mid-sample.
- rx_busy_flag rises the cycle after the start-bit detect and falls the cycle after the stop sample (or on WAIT_IDLE exit).
- rx_valid_flag falls the cycle after rx_read_ack.

## Structure
- Shared UART definitions header:
  - 3-bit state localparams: IDLE=000, START_BIT=001, DATA_BITS=010, STOP_BIT=011, WAIT_IDLE=100. These match the transmit encodings plus WAIT_IDLE.
  - Data width constant, 8.
- One sub-module, uart_rx_sync: SYNC_STAGES-deep synchronizer with preset-to-1 on reset.

## Test plan
- **Loopback with transmit controller, CLKS_PER_BIT=1:** send 8'hA5 → rx_data_byte=8'hA5, rx_valid_flag high at SYNC_STAGES+10 cycles after the start bit; no error or overrun pulses.
- **Back-to-back loopback:** send 8'h00, 8'hFF, 8'h5A with start held high and reads acked immediately → three valid assertions with those bytes in order.
- **Framing error:** drive a frame 8'h3C with stop bit 0, then hold low 20 cycles, then high → one rx_frame_error_flag pulse, rx_valid_flag stays 0, FSM held in WAIT_IDLE, no further frames until the line goes high.
- **Overrun and simultaneous ack:**
  - Receive 8'h11 without ack, then 8'h22 → rx_overrun_flag pulse, rx_data_byte stays 8'h11.
  - Then receive 8'h33 with ack in the completion cycle → rx_data_byte=8'h33, valid stays 1.
- **CLKS_PER_BIT=16:** a 3-clock low glitch → no busy beyond START_BIT, no flags; a full frame 8'hC3 → received correctly.
- **Reset mid-frame:** assert system_reset_n=0 during bit 4 of 8'hF0 → all outputs 0 and FSM in IDLE; the next full frame 8'h81 is received correctly.
